// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_sup_state_e;

    // One counter serves every phase, so it must hold the longest of the three intervals.
    function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                     input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module bit_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a debounced lock with timeout/retry, and gates
// the downstream domain reset on a stable lock.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int  RST_CYCLES    = 16,
    parameter int  LOCK_TIMEOUT  = 100000,
    parameter int  STABLE_CYCLES = 1024,
    parameter int  MAX_RETRY     = 7,
    localparam int RW            = $clog2(MAX_RETRY + 1)
) (
    input  logic           refclk,
    input  logic           rst_n,
    input  logic           locked,
    input  logic           force_relock,
    output logic           pll_rst,
    output logic           domain_rst_n,
    output logic           pll_ready,
    output logic           lost_lock,
    output logic           lock_err,
    output logic [RW-1:0]  retry_cnt,
    output pll_sup_state_e state_dbg
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    pll_sup_state_e state;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  retry_inc;
    logic           lk_s;

    bit_sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (lk_s)
    );

    always_comb begin
        retry_inc = retry_cnt;
        if (retry_cnt != RETRY_MAX) retry_inc = retry_cnt + 1'b1;
    end

    assign state_dbg = state;

    // force_relock is a single-cycle request with no acknowledge: it is honoured on the
    // edge it is sampled high, from any state, and takes priority over everything else.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state        <= PLL_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= 1'b0;
            pll_ready    <= 1'b0;
            lost_lock    <= 1'b0;
            lock_err     <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            lost_lock <= 1'b0;
            if (force_relock) begin
                state        <= PLL_RST;
                cnt          <= '0;
                pll_rst      <= 1'b1;
                domain_rst_n <= 1'b0;
                pll_ready    <= 1'b0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == RST_LAST) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lk_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            retry_cnt <= retry_inc;
                            if (retry_inc == RETRY_MAX) begin
                                lock_err <= 1'b1;
                                state    <= FAIL;
                            end else begin
                                state <= PLL_RST;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STABLE: begin
                        // A dropout only restarts the debounce; it is not a failed attempt.
                        if (!lk_s) begin
                            cnt <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state        <= RUN;
                            cnt          <= '0;
                            retry_cnt    <= '0;
                            domain_rst_n <= 1'b1;
                            pll_ready    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!lk_s) begin
                            state        <= PLL_RST;
                            cnt          <= '0;
                            pll_rst      <= 1'b1;
                            domain_rst_n <= 1'b0;
                            pll_ready    <= 1'b0;
                            lost_lock    <= 1'b1;
                        end
                    end
                    FAIL: begin
                        cnt          <= '0;
                        pll_rst      <= 1'b1;
                        domain_rst_n <= 1'b0;
                        pll_ready    <= 1'b0;
                    end
                    default: begin
                        state        <= PLL_RST;
                        cnt          <= '0;
                        pll_rst      <= 1'b1;
                        domain_rst_n <= 1'b0;
                        pll_ready    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario bench for pll_lock_supervisor: bring-up, timeout/retry, glitch, loss, force, reset.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int RST_CYC = 4;
    localparam int TMO     = 50;
    localparam int STB     = 8;
    localparam int MAXR    = 3;
    localparam int RW      = 2;
    // Synchronizer (2) plus the edge that acts on the synchronized level (1).
    localparam int SYNC_ACT = 3;

    localparam logic [31:0] RST_VEC = {22'd0, 7'b1000000, PLL_RST};

    // clock/reset block
    logic refclk = 1'b0;
    logic rst_n = 1'b0;
    logic locked = 1'b0;
    logic force_relock = 1'b0;
    logic pll_rst, domain_rst_n, pll_ready, lost_lock, lock_err;
    logic [RW-1:0] retry_cnt;
    pll_sup_state_e state_dbg;

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int ll_cnt = 0;
    always @(negedge refclk) if (lost_lock === 1'b1) ll_cnt++;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYC),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .MAX_RETRY     (MAXR)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .pll_ready    (pll_ready),
        .lost_lock    (lost_lock),
        .lock_err     (lock_err),
        .retry_cnt    (retry_cnt),
        .state_dbg    (state_dbg)
    );

    // scoreboard
    logic [31:0] exp_q[$];
    int total = 0;
    int bad = 0;

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic apply_reset(output int r0);
        @(negedge refclk);
        rst_n = 1'b0;
        force_relock = 1'b0;
        step(2);
        rst_n = 1'b1;
        r0 = cyc;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return pll_rst;
            1:       return domain_rst_n;
            default: return lost_lock;
        endcase
    endfunction

    function automatic logic [31:0] out_vec();
        return {22'd0, pll_rst, domain_rst_n, pll_ready, lost_lock, lock_err, retry_cnt, state_dbg};
    endfunction

    // Returns the cycle of the first negedge where the signal has the value, or -1.
    task automatic wait_for(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge refclk);
            if (sig_of(which) === val) begin
                at = cyc;
                return;
            end
        end
    endtask

    // Emulates the PLL: locked rises a fixed delay after pll_rst releases.
    task automatic pll_lock_after_release(input int delay, output int k);
        int f;
        wait_for(0, 1'b0, 40, f);
        step(delay);
        locked = 1'b1;
        k = cyc;
    endtask

    task automatic test_reset();
        int r0;
        logic [31:0] e;
        locked = 1'b0;
        apply_reset(r0);
        exp_q.push_back(RST_VEC);
        e = exp_q.pop_front();
        total++;
        if (out_vec() !== e) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", out_vec(), e);
        end
    endtask

    task automatic test_clean();
        int r0, f, k, at;
        logic [31:0] e;
        locked = 1'b0;
        apply_reset(r0);
        exp_q.push_back(32'(r0 + RST_CYC));
        wait_for(0, 1'b0, 20, f);
        e = exp_q.pop_front();
        total++;
        if (32'(f) !== e) begin
            bad++;
            $display("FAIL clean_prst_width: fall at %0d want %0d", f, e);
        end
        step(10);
        locked = 1'b1;
        k = cyc;
        exp_q.push_back(32'(k + SYNC_ACT + STB));
        wait_for(1, 1'b1, 40, at);
        e = exp_q.pop_front();
        total++;
        if (32'(at) !== e) begin
            bad++;
            $display("FAIL clean_release: got cyc %0d want %0d", at, e);
        end
        exp_q.push_back({22'd0, 7'b0110000, RUN});
        e = exp_q.pop_front();
        total++;
        if (out_vec() !== e) begin
            bad++;
            $display("FAIL clean_run_outputs: got %h want %h", out_vec(), e);
        end
    endtask

    task automatic test_loss();
        int l, at, f, k;
        logic [31:0] e;
        locked = 1'b0;
        l = cyc;
        exp_q.push_back(32'(l + SYNC_ACT));
        wait_for(2, 1'b1, 10, at);
        e = exp_q.pop_front();
        total++;
        if (32'(at) !== e) begin
            bad++;
            $display("FAIL loss_pulse_time: got cyc %0d want %0d", at, e);
        end
        exp_q.push_back({22'd0, 7'b1001000, PLL_RST});
        e = exp_q.pop_front();
        total++;
        if (out_vec() !== e) begin
            bad++;
            $display("FAIL loss_outputs: got %h want %h", out_vec(), e);
        end
        step(1);
        total++;
        if (lost_lock !== 1'b0) begin
            bad++;
            $display("FAIL loss_single_pulse: got %b want 0", lost_lock);
        end
        exp_q.push_back(32'(l + SYNC_ACT + RST_CYC));
        wait_for(0, 1'b0, 20, f);
        e = exp_q.pop_front();
        total++;
        if (32'(f) !== e) begin
            bad++;
            $display("FAIL loss_prst_fall: got cyc %0d want %0d", f, e);
        end
        step(10);
        locked = 1'b1;
        k = cyc;
        exp_q.push_back(32'(k + SYNC_ACT + STB));
        wait_for(1, 1'b1, 40, at);
        e = exp_q.pop_front();
        total++;
        if (32'(at) !== e) begin
            bad++;
            $display("FAIL loss_recover: got cyc %0d want %0d", at, e);
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        total++;
        if (32'(retry_cnt) !== e) begin
            bad++;
            $display("FAIL loss_retry_cnt: got %0d want %0d", retry_cnt, e);
        end
    endtask

    task automatic test_glitch();
        int r0, k, rc, at;
        logic [31:0] e;
        locked = 1'b0;
        apply_reset(r0);
        pll_lock_after_release(10, k);
        step(5 + SYNC_ACT);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        rc = cyc;
        step(SYNC_ACT + STB - 1 - 9 + 2);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        total++;
        if (32'(domain_rst_n) !== e) begin
            bad++;
            $display("FAIL glitch_no_early_release: got %b at cyc %0d want 0", domain_rst_n, cyc);
        end
        exp_q.push_back(32'(rc + 2 + STB));
        wait_for(1, 1'b1, 40, at);
        e = exp_q.pop_front();
        total++;
        if (32'(at) !== e) begin
            bad++;
            $display("FAIL glitch_release: got cyc %0d want %0d", at, e);
        end
    endtask

    task automatic test_timeout();
        int r0, f, at;
        logic [31:0] e;
        locked = 1'b0;
        apply_reset(r0);
        exp_q.push_back(32'(r0 + RST_CYC));
        wait_for(0, 1'b0, 20, f);
        e = exp_q.pop_front();
        total++;
        if (32'(f) !== e) begin
            bad++;
            $display("FAIL timeout_first_fall: got cyc %0d want %0d", f, e);
        end
        for (int i = 0; i < MAXR; i++) begin
            exp_q.push_back(32'(f + TMO));
            wait_for(0, 1'b1, TMO + 20, at);
            e = exp_q.pop_front();
            total++;
            if (32'(at) !== e) begin
                bad++;
                $display("FAIL timeout_rise_%0d: got cyc %0d want %0d", i, at, e);
            end
            exp_q.push_back({29'd0, (i == MAXR - 1), 2'(i + 1)});
            e = exp_q.pop_front();
            total++;
            if ({29'd0, lock_err, retry_cnt} !== e) begin
                bad++;
                $display("FAIL timeout_err_retry_%0d: got err=%b retry=%0d want %h",
                         i, lock_err, retry_cnt, e);
            end
            if (i < MAXR - 1) begin
                exp_q.push_back(32'(at + RST_CYC));
                wait_for(0, 1'b0, 20, f);
                e = exp_q.pop_front();
                total++;
                if (32'(f) !== e) begin
                    bad++;
                    $display("FAIL timeout_fall_%0d: got cyc %0d want %0d", i, f, e);
                end
            end
        end
        step(30);
        exp_q.push_back({27'd0, 1'b1, 1'b0, FAIL});
        e = exp_q.pop_front();
        total++;
        if ({27'd0, pll_rst, domain_rst_n, state_dbg} !== e) begin
            bad++;
            $display("FAIL timeout_fail_stuck: got %h want %h",
                     {27'd0, pll_rst, domain_rst_n, state_dbg}, e);
        end
    endtask

    // Starts in FAIL, left there by test_timeout.
    task automatic test_force();
        int ll0, p, f, k, at, q;
        logic [31:0] e;
        ll0 = ll_cnt;
        force_relock = 1'b1;
        p = cyc;
        step(1);
        force_relock = 1'b0;
        exp_q.push_back({25'd0, 1'b1, 1'b1, 2'(MAXR), PLL_RST});
        e = exp_q.pop_front();
        total++;
        if ({25'd0, pll_rst, lock_err, retry_cnt, state_dbg} !== e) begin
            bad++;
            $display("FAIL force_from_fail: got %h want %h",
                     {25'd0, pll_rst, lock_err, retry_cnt, state_dbg}, e);
        end
        exp_q.push_back(32'(p + 1 + RST_CYC));
        wait_for(0, 1'b0, 20, f);
        e = exp_q.pop_front();
        total++;
        if (32'(f) !== e) begin
            bad++;
            $display("FAIL force_prst_fall: got cyc %0d want %0d", f, e);
        end
        step(10);
        locked = 1'b1;
        k = cyc;
        exp_q.push_back(32'(k + SYNC_ACT + STB));
        wait_for(1, 1'b1, 40, at);
        e = exp_q.pop_front();
        total++;
        if (32'(at) !== e) begin
            bad++;
            $display("FAIL force_relock_run: got cyc %0d want %0d", at, e);
        end
        exp_q.push_back({29'd0, 1'b1, 2'd0});
        e = exp_q.pop_front();
        total++;
        if ({29'd0, lock_err, retry_cnt} !== e) begin
            bad++;
            $display("FAIL force_err_sticky: got err=%b retry=%0d want %h", lock_err, retry_cnt, e);
        end
        // Force arrives on the same edge the synchronized lock falls.
        locked = 1'b0;
        q = cyc;
        step(SYNC_ACT - 1);
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        exp_q.push_back({24'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, PLL_RST});
        e = exp_q.pop_front();
        total++;
        if ({24'd0, lost_lock, domain_rst_n, pll_rst, pll_ready, lock_err, state_dbg} !== e) begin
            bad++;
            $display("FAIL force_in_run: got %h want %h at cyc %0d (lock drop %0d)",
                     {24'd0, lost_lock, domain_rst_n, pll_rst, pll_ready, lock_err, state_dbg},
                     e, cyc, q);
        end
        step(5);
        exp_q.push_back(32'(ll0));
        e = exp_q.pop_front();
        total++;
        if (32'(ll_cnt) !== e) begin
            bad++;
            $display("FAIL force_no_lost_lock: got %0d pulses want %0d", ll_cnt, e);
        end
    endtask

    task automatic test_rst_mid();
        int r0, k, at;
        logic [31:0] e;
        locked = 1'b0;
        apply_reset(r0);
        pll_lock_after_release(0, k);
        locked = 1'b0;
        step(20);
        rst_n = 1'b0;
        step(1);
        exp_q.push_back(RST_VEC);
        e = exp_q.pop_front();
        total++;
        if (out_vec() !== e) begin
            bad++;
            $display("FAIL rst_mid_wait: got %h want %h", out_vec(), e);
        end
        rst_n = 1'b1;
        pll_lock_after_release(10, k);
        exp_q.push_back(32'(k + SYNC_ACT + STB));
        wait_for(1, 1'b1, 40, at);
        e = exp_q.pop_front();
        total++;
        if (32'(at) !== e) begin
            bad++;
            $display("FAIL rst_mid_release: got cyc %0d want %0d", at, e);
        end
        step(5);
        rst_n = 1'b0;
        step(1);
        exp_q.push_back(RST_VEC);
        e = exp_q.pop_front();
        total++;
        if (out_vec() !== e) begin
            bad++;
            $display("FAIL rst_mid_run: got %h want %h", out_vec(), e);
        end
        rst_n = 1'b1;
        locked = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_loss();
        test_glitch();
        test_timeout();
        test_force();
        test_rst_mid();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d expected entries left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
